// File: rtl/trigger_pkg.sv
// Shared constants for the shock-tube trigger chain: output FSM encodings
// and timestamp limits.
package trigger_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int                TS_W    = 32;
    localparam logic [TS_W-1:0]   TS_MAX  = {TS_W{1'b1}};
    localparam int                TICK_NS = 8;

endpackage

// File: rtl/trigger_stamp_out_edge_stamp.sv
// One detect bit: rising-edge detector plus a first-capture timestamp
// register that holds until the soft reset (disarm) clears it.
module edge_stamp
    import trigger_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         srst,
    input  logic         din,
    input  logic [W-1:0] time_cnt,
    output logic         edge_pls,
    output logic [W-1:0] ts,
    output logic         valid
);

    logic         q_r;
    logic [W-1:0] ts_r;
    logic         valid_r;

    assign edge_pls = din & ~q_r;
    assign ts       = ts_r;
    assign valid    = valid_r;

    // Delayed copy of the input; keeps tracking while disarmed so a level
    // already high at arming never looks like an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= 1'b0;
        end else begin
            q_r <= din;
        end
    end

    // First edge after arming wins; later edges leave the stamp untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts_r    <= {W{1'b0}};
            valid_r <= 1'b0;
        end else if (srst) begin
            ts_r    <= {W{1'b0}};
            valid_r <= 1'b0;
        end else if (edge_pls && !valid_r) begin
            ts_r    <= time_cnt;
            valid_r <= 1'b1;
        end
    end

endmodule

// File: rtl/trigger_stamp_out.sv
// Timestamps trigger_gen detection events relative to arming, derives the
// A->B time of flight and drives the programmable-width trigger output.
module trigger_stamp_out
    import trigger_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int TRIG_ACTIVE_HIGH   = 1,
    parameter int N_STAMP            = 4
) (
    input  logic                                  rxclk,
    input  logic                                  rx_resetn,
    input  logic                                  trig_enable,
    input  logic [7:0]                            detect_pls,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]         pulse_width,
    output logic                                  trig_out,
    output logic [N_STAMP*C_S_AXI_DATA_WIDTH-1:0] ts_pls,
    output logic [N_STAMP-1:0]                    ts_valid,
    output logic [C_S_AXI_DATA_WIDTH-1:0]         tof_ab,
    output logic                                  trig_done
);

    localparam int             W        = C_S_AXI_DATA_WIDTH;
    localparam logic [W-1:0]   ZERO_W   = {W{1'b0}};
    localparam logic [W-1:0]   ONE_W    = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0]   CNT_MAX  = {W{1'b1}};
    localparam logic           ACT_LVL  = (TRIG_ACTIVE_HIGH != 0) ? 1'b1 : 1'b0;
    localparam logic           IDLE_LVL = (TRIG_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

    function automatic logic [W-1:0] width_min1(input logic [W-1:0] pw);
        if (pw == ZERO_W) begin
            return ONE_W;
        end else begin
            return pw;
        end
    endfunction

    logic               srst_s;
    logic [W-1:0]       time_cnt_r;
    logic [N_STAMP-1:0] edge_s;
    logic               fire_edge_s;
    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [W-1:0]       hold_cnt_r;
    logic [W-1:0]       hold_nxt_s;
    logic               pulse_on_nxt_s;
    logic               done_nxt_s;
    logic               trig_out_r;
    logic               trig_done_r;
    logic [W-1:0]       tof_r;
    logic               unused_detect_s;

    // Disarm acts as the synchronous clear of the whole block.
    assign srst_s          = ~trig_enable;
    assign fire_edge_s     = edge_s[N_STAMP-1];
    assign unused_detect_s = ^{detect_pls, edge_s};

    assign trig_out  = trig_out_r;
    assign trig_done = trig_done_r;
    assign tof_ab    = tof_r;

    // Arming-relative time base, saturating rather than wrapping.
    always_ff @(posedge rxclk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            time_cnt_r <= ZERO_W;
        end else if (srst_s) begin
            time_cnt_r <= ZERO_W;
        end else if (time_cnt_r != CNT_MAX) begin
            time_cnt_r <= time_cnt_r + ONE_W;
        end
    end

    for (genvar k = 1; k <= N_STAMP; k++) begin : g_stamp
        edge_stamp #(
            .W (W)
        ) u_stamp (
            .clk      (rxclk),
            .rst_n    (rx_resetn),
            .srst     (srst_s),
            .din      (detect_pls[k]),
            .time_cnt (time_cnt_r),
            .edge_pls (edge_s[k-1]),
            .ts       (ts_pls[(k-1)*W +: W]),
            .valid    (ts_valid[k-1])
        );
    end

    // Time of flight between probes A and B once both stamps exist.
    always_ff @(posedge rxclk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            tof_r <= ZERO_W;
        end else if (srst_s) begin
            tof_r <= ZERO_W;
        end else if (ts_valid[1:0] == 2'b11) begin
            tof_r <= ts_pls[W +: W] - ts_pls[0 +: W];
        end
    end

    // Output FSM next-state; pulse_on_nxt_s is the trigger level for the next cycle.
    always_comb begin
        state_nxt_s    = state_r;
        hold_nxt_s     = hold_cnt_r;
        pulse_on_nxt_s = 1'b0;
        done_nxt_s     = trig_done_r;
        if (srst_s) begin
            state_nxt_s = ST_IDLE;
            hold_nxt_s  = ZERO_W;
            done_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ARMED;
                end
                ST_ARMED: begin
                    if (fire_edge_s) begin
                        state_nxt_s    = ST_PULSE;
                        hold_nxt_s     = width_min1(pulse_width);
                        pulse_on_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = ST_ARMED;
                    end
                end
                ST_PULSE: begin
                    if (hold_cnt_r == ONE_W) begin
                        state_nxt_s = ST_DONE;
                        hold_nxt_s  = ZERO_W;
                        done_nxt_s  = 1'b1;
                    end else begin
                        hold_nxt_s     = hold_cnt_r - ONE_W;
                        pulse_on_nxt_s = 1'b1;
                    end
                end
                ST_DONE: begin
                    done_nxt_s = 1'b1;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    hold_nxt_s  = ZERO_W;
                    done_nxt_s  = 1'b0;
                end
            endcase
        end
    end

    // FSM state, pulse hold counter and registered outputs.
    always_ff @(posedge rxclk or negedge rx_resetn) begin
        if (!rx_resetn) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= ZERO_W;
            trig_out_r  <= IDLE_LVL;
            trig_done_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            hold_cnt_r  <= hold_nxt_s;
            trig_out_r  <= pulse_on_nxt_s ? ACT_LVL : IDLE_LVL;
            trig_done_r <= done_nxt_s;
        end
    end

endmodule

// File: tb/tb_trigger_stamp_out.sv
// Directed bench for trigger_stamp_out: both output polarities driven from
// the same stimulus, expected values worked out by hand.
module tb_trigger_stamp_out;

    logic         rxclk;
    logic         rx_resetn;
    logic         trig_enable;
    logic [7:0]   detect_pls;
    logic [31:0]  pulse_width;
    logic         trig_out;
    logic         trig_out_n;
    logic [127:0] ts_pls;
    logic [127:0] ts_pls_n;
    logic [3:0]   ts_valid;
    logic [3:0]   ts_valid_n;
    logic [31:0]  tof_ab;
    logic [31:0]  tof_ab_n;
    logic         trig_done;
    logic         trig_done_n;

    int n_cmp;
    int n_err;

    trigger_stamp_out #(
        .C_S_AXI_DATA_WIDTH (32),
        .TRIG_ACTIVE_HIGH   (1),
        .N_STAMP            (4)
    ) dut (
        .rxclk       (rxclk),
        .rx_resetn   (rx_resetn),
        .trig_enable (trig_enable),
        .detect_pls  (detect_pls),
        .pulse_width (pulse_width),
        .trig_out    (trig_out),
        .ts_pls      (ts_pls),
        .ts_valid    (ts_valid),
        .tof_ab      (tof_ab),
        .trig_done   (trig_done)
    );

    trigger_stamp_out #(
        .C_S_AXI_DATA_WIDTH (32),
        .TRIG_ACTIVE_HIGH   (0),
        .N_STAMP            (4)
    ) dut_n (
        .rxclk       (rxclk),
        .rx_resetn   (rx_resetn),
        .trig_enable (trig_enable),
        .detect_pls  (detect_pls),
        .pulse_width (pulse_width),
        .trig_out    (trig_out_n),
        .ts_pls      (ts_pls_n),
        .ts_valid    (ts_valid_n),
        .tof_ab      (tof_ab_n),
        .trig_done   (trig_done_n)
    );

    initial rxclk = 1'b0;
    always #4 rxclk = ~rxclk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge rxclk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
        end
    endtask

    task automatic check_cleared(input string tag);
        check_val({tag, "_trig"},   {31'd0, trig_out},   32'd0);
        check_val({tag, "_trig_n"}, {31'd0, trig_out_n}, 32'd1);
        check_val({tag, "_valid"},  {28'd0, ts_valid},   32'd0);
        check_val({tag, "_ts"},     {31'd0, |ts_pls},    32'd0);
        check_val({tag, "_tof"},    tof_ab,              32'd0);
        check_val({tag, "_done"},   {31'd0, trig_done},  32'd0);
    endtask

    task automatic disarm();
        trig_enable = 1'b0;
        detect_pls  = 8'h00;
        ticks(2);
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        rx_resetn   = 1'b0;
        trig_enable = 1'b0;
        detect_pls  = 8'h00;
        pulse_width = 32'd5;

        ticks(3);
        check_cleared("reset");
        rx_resetn = 1'b1;
        ticks(2);
        check_cleared("idle");

        // Probe A at time 100, probe B at time 2700
        trig_enable = 1'b1;
        ticks(100);
        detect_pls = 8'b0000_0010;
        tick();
        check_val("tA_slot0",  ts_pls[31:0],     32'd100);
        check_val("tA_valid",  {28'd0, ts_valid}, 32'h1);
        ticks(2599);
        detect_pls = 8'b0000_0110;
        tick();
        check_val("tA_slot1",  ts_pls[63:32],    32'd2700);
        check_val("tA_valid2", {28'd0, ts_valid}, 32'h3);
        check_val("tA_tof_pre", tof_ab,          32'd0);
        tick();
        check_val("tA_tof",    tof_ab,           32'd2600);
        check_val("tA_tof_n",  tof_ab_n,         32'd2600);
        check_val("tA_notrig", {31'd0, trig_out}, 32'd0);
        disarm();
        check_cleared("disarmA");

        // 5-cycle pulse fired at time 50; width change mid-pulse ignored
        pulse_width = 32'd5;
        trig_enable = 1'b1;
        ticks(50);
        detect_pls = 8'b0001_0000;
        tick();
        pulse_width = 32'd9;
        check_val("tB_slot3",   ts_pls[127:96],     32'd50);
        check_val("tB_valid",   {28'd0, ts_valid},  32'h8);
        check_val("tB_on1",     {31'd0, trig_out},  32'd1);
        check_val("tB_on1_n",   {31'd0, trig_out_n}, 32'd0);
        for (int i = 2; i <= 5; i++) begin
            tick();
            check_val($sformatf("tB_on%0d", i), {31'd0, trig_out}, 32'd1);
        end
        check_val("tB_done_mid", {31'd0, trig_done}, 32'd0);
        tick();
        check_val("tB_off",     {31'd0, trig_out},   32'd0);
        check_val("tB_off_n",   {31'd0, trig_out_n}, 32'd1);
        check_val("tB_done",    {31'd0, trig_done},  32'd1);
        detect_pls = 8'h00;
        tick();
        detect_pls = 8'b0001_0000;
        tick();
        tick();
        check_val("tB_noretrig", {31'd0, trig_out},  32'd0);
        check_val("tB_first",   ts_pls[127:96],      32'd50);
        check_val("tB_done2",   {31'd0, trig_done},  32'd1);
        disarm();

        // Zero width behaves as a single-cycle pulse
        pulse_width = 32'd0;
        trig_enable = 1'b1;
        ticks(10);
        detect_pls = 8'b0001_0000;
        tick();
        check_val("tC_on",   {31'd0, trig_out},  32'd1);
        tick();
        check_val("tC_off",  {31'd0, trig_out},  32'd0);
        check_val("tC_done", {31'd0, trig_done}, 32'd1);
        disarm();

        // Bit 3 high before arming, bits 1 and 2 rising together at 20
        detect_pls = 8'b0000_1000;
        tick();
        trig_enable = 1'b1;
        ticks(20);
        detect_pls = 8'b0000_1110;
        tick();
        check_val("tD_valid", {28'd0, ts_valid}, 32'h3);
        check_val("tD_slot0", ts_pls[31:0],      32'd20);
        check_val("tD_slot1", ts_pls[63:32],     32'd20);
        tick();
        check_val("tD_tof",   tof_ab,            32'd0);
        detect_pls = 8'b0000_1100;
        tick();
        detect_pls = 8'b0000_1110;
        tick();
        check_val("tD_keep0", ts_pls[31:0],      32'd20);
        check_val("tD_valid2", {28'd0, ts_valid}, 32'h3);
        disarm();

        // Disarm on cycle 3 of a 10-cycle pulse, then re-arm
        pulse_width = 32'd10;
        trig_enable = 1'b1;
        ticks(5);
        detect_pls = 8'b0001_0000;
        tick();
        check_val("tE_on1", {31'd0, trig_out}, 32'd1);
        ticks(2);
        check_val("tE_on3", {31'd0, trig_out}, 32'd1);
        trig_enable = 1'b0;
        tick();
        check_cleared("tE_drop");
        detect_pls  = 8'h00;
        trig_enable = 1'b1;
        ticks(7);
        detect_pls = 8'b0000_0010;
        tick();
        check_val("tE_restart", ts_pls[31:0], 32'd7);
        disarm();

        // Asynchronous reset in the middle of a pulse
        pulse_width = 32'd10;
        trig_enable = 1'b1;
        ticks(3);
        detect_pls = 8'b0001_0010;
        tick();
        tick();
        check_val("tF_on",   {31'd0, trig_out},   32'd1);
        check_val("tF_on_n", {31'd0, trig_out_n}, 32'd0);
        #1;
        rx_resetn = 1'b0;
        #1;
        check_cleared("tF_async");
        tick();
        rx_resetn   = 1'b1;
        trig_enable = 1'b0;
        detect_pls  = 8'h00;
        ticks(2);
        check_cleared("tF_after");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trigger_stamp_out.md
Name: trigger_stamp_out

Overview:
- Downstream consumer of the trigger_gen detect_pls bus in the shock-tube trigger/DAQ chain.
- Timestamps each detection event (probe A, B, C, final trigger) relative to arming.
- Drives the physical trigger output as a programmable-width pulse.
- Exposes timestamps and the A→B time-of-flight to the AXI register bank.

Parameters:
- C_S_AXI_DATA_WIDTH, 32, width of timestamps, counters and config words.
- TRIG_ACTIVE_HIGH, 1, output polarity: 1 = trig_out idles 0 and pulses 1; 0 = inverted.
- N_STAMP, 4, number of stamped detect bits (detect_pls[N_STAMP:1]); bit N_STAMP fires the output.

Ports:
- rxclk  in  1  125 MHz ADC-side clock, 8 ns per tick.
- rx_resetn  in  1  reset: asynchronous assert, active-low.
- trig_enable  in  1  arm/clear; same signal that drives trigger_gen.
- detect_pls  in  8  event flags from trigger_gen; sticky-high once set.
- pulse_width  in  32  trig_out high time in rxclk cycles; 0 is treated as 1.
- trig_out  out  1  physical trigger output.
- ts_pls  out  4*32  packed timestamps; slot k-1 holds the capture for detect_pls[k].
- ts_valid  out  4  ts_pls slot k holds a valid capture.
- tof_ab  out  32  ts of bit 2 minus ts of bit 1, modulo 2^32; 0 until both are valid.
- trig_done  out  1  output pulse completed since arming.

Behaviour:
- Reset values:
  - trig_out = inactive level (0 if TRIG_ACTIVE_HIGH, else 1).
  - ts_pls = 0, ts_valid = 0, tof_ab = 0, trig_done = 0.
  - time_cnt = 0, detect_q = 0x00, state = IDLE.
- Clear while disarmed: whenever trig_enable = 0, synchronously force all of the above to reset values, except detect_q <= detect_pls. An input already high at arming therefore produces no edge.
- Time counter (time_cnt):
  - Cycle after trig_enable rises: time_cnt = 0.
  - Then +1 per cycle while enabled.
  - Saturates at 0xFFFF_FFFF; no wrap.
- Edge detection:
  - Registered copy detect_q <= detect_pls every cycle.
  - Edge for bit k = detect_pls[k] & ~detect_q[k].
- Stamp capture:
  - On an edge for bit k (1..4) with ts_valid[k-1] = 0, capture the time_cnt value of that same cycle into slot k-1 at the next clock, and set ts_valid[k-1].
  - Later edges on a captured bit are ignored; first capture wins until disarm.
  - Several bits edging in one cycle capture identical values.
- tof_ab: registered; updates one cycle after ts_valid[1:0] becomes 2'b11. Unsigned subtract, modulo 2^32.
- FSM states:
  - IDLE: trig_enable = 0. When trig_enable = 1 → ARMED.
  - ARMED: on edge of detect_pls[N_STAMP] → PULSE. Next cycle trig_out is active; latch width = max(pulse_width, 1) into hold_cnt.
  - PULSE: trig_out active. hold_cnt decrements each cycle; when hold_cnt = 1 → DONE. Total active time is exactly width cycles.
  - DONE: trig_out inactive, trig_done = 1. Held until disarm; no retrigger.
  - Any state with trig_enable = 0 → IDLE next cycle, trig_out inactive at once (including mid-pulse).
- Latency: detect_pls[4] rises at cycle t → trig_out active at t+1, ts_pls[3] = time_cnt(t) at t+1.
- Config timing: pulse_width changes during PULSE have no effect on the current pulse (latched value used).
- Async reset mid-pulse: trig_out returns to inactive immediately; all state is cleared.
- Invalid state encodings recover to IDLE.

Decomposition:
- Shared package (trigger_pkg): FSM state localparams (IDLE, ARMED, PULSE, DONE), TS_MAX = all-ones, TICK_NS = 8.
- One sub-module, edge_stamp: single-bit edge detector plus first-capture timestamp register with valid flag. Instantiated N_STAMP times in a generate loop.

Test Plan:
- Arm; raise detect_pls bit 1 at time_cnt = 100 and bit 2 at time_cnt = 2700 → ts_pls slot 0 = 100, slot 1 = 2700, ts_valid = 4'b0011, tof_ab = 2600 one cycle later.
- pulse_width = 5; raise detect_pls[4] at time_cnt = 50 → trig_out active for exactly 5 cycles starting 1 cycle later, ts_pls slot 3 = 50, trig_done = 1 afterwards.
- pulse_width = 0 → trig_out active for exactly 1 cycle.
- Bit 3 already high when trig_enable rises → no capture (ts_valid[2] = 0); bits 1 and 2 rising in the same cycle → equal stamps.
- Drop trig_enable on cycle 3 of a 10-cycle pulse → trig_out inactive next cycle, all outputs 0. Re-arm → time_cnt restarts at 0.
- Assert rx_resetn = 0 asynchronously mid-PULSE → trig_out inactive without waiting for a clock edge, all registers at reset values. TRIG_ACTIVE_HIGH = 0 build → idle level 1, pulse level 0.
